// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, serial-controller state encoding, default width
// and small opcode decode helpers used by both the controller and the bit slice.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Subtract-style ops run the adder as a + ~b + 1.
  function automatic logic op_inverts(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Only ADD/SUB report carry and overflow flags.
  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder with optional B inversion plus bitwise ops.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       carry_i,
  input  logic       invert_i,
  input  logic [3:0] op_i,
  output logic       result_o,
  output logic       carry_o,
  output logic       sum_o
);

  logic w_b;

  assign w_b     = b_i ^ invert_i;
  assign sum_o   = a_i ^ w_b ^ carry_i;
  assign carry_o = (a_i & w_b) | (a_i & carry_i) | (w_b & carry_i);

  // Select the per-bit result; SLT bits are zero here and fixed up at the end.
  always_comb begin
    result_o = 1'b0;
    case (op_i)
      OP_AND:         result_o = a_i & b_i;
      OP_OR:          result_o = a_i | b_i;
      OP_XOR:         result_o = a_i ^ b_i;
      OP_ADD, OP_SUB: result_o = sum_o;
      default:        result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: processes one bit per cycle LSB first through a
// single alu_bit_slice, then publishes result and flags with a done pulse.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CntW-1:0]  r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic             r_ovf;
  logic             r_msb;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_cflag;
  logic             r_vflag;

  logic             w_accept;
  logic             w_last;
  logic             w_invert;
  logic             w_res_bit;
  logic             w_cout;
  logic             w_sum;
  logic [WIDTH-1:0] w_final;

  // The done cycle still counts as busy so a new start lands the cycle after done.
  assign busy_o   = (r_state != ST_IDLE) | r_done;
  assign w_accept = start_i & ~busy_o;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LastBit);
  assign w_invert = op_inverts(r_op);
  // SLT: sign of the difference corrected by signed overflow.
  assign w_final  = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, r_msb ^ r_ovf} : r_sh;

  assign done_o     = r_done;
  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign carry_o    = r_cflag;
  assign overflow_o = r_vflag;

  alu_bit_slice u_slice (
    .a_i      (r_a[0]),
    .b_i      (r_b[0]),
    .carry_i  (r_carry),
    .invert_i (w_invert),
    .op_i     (r_op),
    .result_o (w_res_bit),
    .carry_o  (w_cout),
    .sum_o    (w_sum)
  );

  // Sequencer: IDLE -> RUN for WIDTH bits -> FIN -> IDLE, bit counter and carry chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_carry <= op_inverts(op_i);
          end
        end
        ST_RUN: begin
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CntW'(1);
          if (r_cnt == LastBit) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers; the operand LSBs feed the slice.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sh  <= '0;
      r_op  <= OP_AND;
      r_ovf <= 1'b0;
      r_msb <= 1'b0;
    end else if (w_accept) begin
      r_a  <= a_i;
      r_b  <= b_i;
      r_op <= op_i;
    end else if (r_state == ST_RUN) begin
      r_a  <= r_a >> 1;
      r_b  <= r_b >> 1;
      r_sh <= {w_res_bit, r_sh[WIDTH-1:1]};
      if (w_last) begin
        r_ovf <= r_carry ^ w_cout;
        r_msb <= w_sum;
      end
    end
  end

  // Published result and flags, updated together with the done pulse and then held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_cflag  <= 1'b0;
      r_vflag  <= 1'b0;
    end else if (r_state == ST_FIN) begin
      r_result <= w_final;
      r_zero   <= (w_final == '0);
      r_cflag  <= op_is_arith(r_op) & r_carry;
      r_vflag  <= op_is_arith(r_op) & r_ovf;
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: the stimulus pushes expected results from
// an arithmetic reference model, a monitor pops and compares on every done_o.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 32;

  localparam logic [3:0] T_AND = 4'b0000;
  localparam logic [3:0] T_OR  = 4'b0001;
  localparam logic [3:0] T_ADD = 4'b0010;
  localparam logic [3:0] T_XOR = 4'b0100;
  localparam logic [3:0] T_SUB = 4'b0110;
  localparam logic [3:0] T_SLT = 4'b0111;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         zero;
  logic         carry;
  logic         ovf;

  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_r = '0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (res),
    .zero_o     (zero),
    .carry_o    (carry),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model built from plain two's-complement arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] t;
    e.r = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0;
    case (o)
      T_AND: e.r = x & y;
      T_OR:  e.r = x | y;
      T_XOR: e.r = x ^ y;
      T_ADD: begin
        t   = {1'b0, x} + {1'b0, y};
        e.r = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      T_SUB: begin
        t   = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        e.r = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      T_SLT: e.r = ($signed(x) < $signed(y)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", {32'd0, res}, {32'd0, mon_e.r});
        check("zero", {63'd0, zero}, {63'd0, mon_e.z});
        check("carry", {63'd0, carry}, {63'd0, mon_e.c});
        check("overflow", {63'd0, ovf}, {63'd0, mon_e.v});
        check("latency", 64'(cyc - mon_e.acc), 64'(W + 1));
        last_r = mon_e.r;
      end
    end
  end

  // Called at a negedge; waits for idle, issues one op, returns at the next negedge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit expect_it);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    if (expect_it) begin
      e     = model(o, x, y);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  logic [3:0]   ops[7];
  logic [W-1:0] specials[5];
  logic [W-1:0] x, y;

  initial begin
    ops      = '{T_AND, T_OR, T_ADD, T_SUB, T_SLT, T_XOR, 4'b1011};
    specials = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, res}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_carry", {63'd0, carry}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases
    issue(T_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    issue(T_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1);
    issue(T_SLT, 32'h8000_0000, 32'h0000_0001, 1'b1);
    issue(T_SLT, 32'h0000_0003, 32'hFFFF_FFFB, 1'b1);
    issue(T_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    issue(T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    issue(T_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    drain();

    // Result must hold after done until the next acceptance
    repeat (3) @(negedge clk);
    check("result_held", {32'd0, res}, {32'd0, last_r});

    // Start during a busy ADD (cycle 10) must be ignored
    issue(T_ADD, 32'h0000_1111, 32'h0000_2222, 1'b1);
    repeat (9) @(negedge clk);
    op = T_ADD; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held through the FIN and done cycles must be ignored
    issue(T_SUB, 32'h0000_0010, 32'h0000_0020, 1'b1);
    repeat (W - 1) @(negedge clk);
    op = T_SUB; a = 32'h5555_5555; b = 32'h1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);

    // Reset at cycle 15 of a SUB aborts it; a new op is accepted right after
    issue(T_SUB, 32'hCAFE_0000, 32'h0000_BEEF, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    start = 1'b1; op = T_ADD;
    @(negedge clk);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_result", {32'd0, res}, 64'd0);
    check("abort_zero", {63'd0, zero}, 64'd1);
    check("abort_carry", {63'd0, carry}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0; start = 1'b0;
    issue(T_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    drain();

    // Randomized traffic, including operand corner values and an illegal code
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) y = specials[$urandom_range(0, 4)];
      issue(ops[$urandom_range(0, 6)], x, y, 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 2).
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request; accepted only when busy_o = 0.
REQ-005 op_i  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0100 XOR; other codes illegal.
REQ-006 a_i  input  WIDTH  operand A, sampled on accepted start.
REQ-007 b_i  input  WIDTH  operand B, sampled on accepted start.
REQ-008 busy_o  output  1  high from the cycle after acceptance until done_o.
REQ-009 done_o  output  1  one-cycle pulse, result valid.
REQ-010 result_o  output  WIDTH  result, held stable from done_o until next acceptance.
REQ-011 zero_o  output  1  result_o == 0, valid with done_o, held.
REQ-012 carry_o  output  1  carry out of MSB (ADD/SUB only, else 0), held.
REQ-013 overflow_o  output  1  signed overflow (ADD/SUB only, else 0), held.

Function
REQ-014 The block SHALL compute one result bit per cycle, LSB first, through a single 1-bit slice.
REQ-015 FSM states SHALL be IDLE, RUN, FIN; IDLE->RUN on start_i; RUN->FIN after bit WIDTH-1; FIN->IDLE unconditionally.
REQ-016 On acceptance, a_i, b_i, op_i SHALL be captured; bit counter cleared; carry register loaded with 1 for SUB/SLT, 0 otherwise.
REQ-017 Slice invert SHALL be 1 for SUB/SLT, 0 otherwise; carry register SHALL update from slice carry-out every RUN cycle.
REQ-018 For SLT, RUN SHALL write 0 to every result bit; in FIN result bit 0 SHALL be set to (MSB difference XOR signed overflow).
REQ-019 Signed overflow SHALL be carry-into-MSB XOR carry-out-of-MSB, captured in the last RUN cycle.
REQ-020 done_o SHALL assert in FIN; latency from accepting edge to done_o SHALL be exactly WIDTH+1 cycles.
REQ-021 Illegal op_i SHALL produce result 0, zero_o 1, carry_o 0, overflow_o 0, same latency.
REQ-022 start_i while busy_o = 1 SHALL be ignored with no effect on the running operation.
REQ-023 start_i asserted in the FIN cycle SHALL be ignored; back-to-back issue earliest the cycle after done_o.
REQ-024 Operand inputs SHALL be don't-care after acceptance.

Reset
REQ-025 rst_i SHALL force IDLE, busy_o 0, done_o 0, result_o 0, zero_o 1, carry_o 0, overflow_o 0, counter and carry register 0.
REQ-026 rst_i mid-operation SHALL abort without asserting done_o; rst_i has priority over start_i in the same cycle.

Structure
REQ-027 Opcodes, FSM state encoding and default WIDTH SHALL live in shared package alu_pkg, shared with ALU decode logic.
REQ-028 The bitwise datapath SHALL be one instance of sub-module alu_bit_slice (a, b, carry-in, invert, op -> result, carry-out, sum).
REQ-029 Operand and result storage SHALL be shift registers; counter width SHALL be clog2(WIDTH).

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow_o 1, carry_o 0, done_o 33 cycles after start.
REQ-031 SUB 0x00000005 - 0x00000005 -> result 0, zero_o 1, carry_o 1, overflow_o 0.
REQ-032 SLT 0x80000000 vs 0x00000001 -> result 0x00000001; SLT 0x00000003 vs 0xFFFFFFFB -> result 0.
REQ-033 XOR 0xF0F0F0F0 ^ 0xFF00FF00 -> 0x0FF00FF0; AND/OR same operands -> 0xF000F000 / 0xFFF0FFF0.
REQ-034 Second start_i at cycle 10 of a busy ADD with different operands -> first result unchanged, single done_o.
REQ-035 rst_i at cycle 15 of a SUB -> no done_o, all outputs at reset values next cycle; new start accepted following cycle.
